// File: rtl/p20_video_pkg.sv
// Shared constants and pipeline payload types for the dino game pixel renderer.
package p20_video_pkg;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned RGB_W       = 6;
    localparam int unsigned DINO_H_W    = 7;
    localparam int unsigned ROW_W       = 4;

    localparam int unsigned H_VISIBLE   = 640;
    localparam int unsigned V_VISIBLE   = 480;
    localparam int unsigned TICK_ROW    = 480;

    localparam int unsigned SPRITE_W    = 16;
    localparam int unsigned SPRITE_H    = 16;
    localparam int unsigned SCALE_SHIFT = 1;

    localparam int unsigned OBS_W       = 16;
    localparam int unsigned OBS_H       = 32;

    localparam logic [RGB_W-1:0] COL_DINO   = 6'b010101;
    localparam logic [RGB_W-1:0] COL_OBS    = 6'b001000;
    localparam logic [RGB_W-1:0] COL_GROUND = 6'b101010;
    localparam logic [RGB_W-1:0] COL_BG     = 6'b111111;

    // Per-pixel classification carried from stage 1 to stage 2.
    typedef struct packed {
        logic             vis;
        logic             dino;
        logic             obs;
        logic             ground;
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] col;
    } pix_flags_t;

endpackage

// File: rtl/p20_dino_rom.sv
// 16x16 1bpp dino sprite; bit 15 of each row is the leftmost column.
module p20_dino_rom
    import p20_video_pkg::*;
(
    input  logic [ROW_W-1:0]    row,
    output logic [SPRITE_W-1:0] data
);

    always_comb begin
        data = '0;
        case (row)
            4'h0: data = 16'hC07E;
            4'h1: data = 16'hC0FF;
            4'h2: data = 16'hC0DF;
            4'h3: data = 16'hC0FF;
            4'h4: data = 16'hC0F0;
            4'h5: data = 16'hC0FC;
            4'h6: data = 16'hE1E0;
            4'h7: data = 16'hF3E0;
            4'h8: data = 16'hFFF8;
            4'h9: data = 16'hFFE8;
            4'hA: data = 16'h7FE0;
            4'hB: data = 16'h3FC0;
            4'hC: data = 16'h1F80;
            4'hD: data = 16'h1980;
            4'hE: data = 16'h1100;
            4'hF: data = 16'h1980;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/p20_video_out.sv
// Dino game pixel renderer: 2-stage RGB/sync pipeline, frame tick, state shadowing, collision.
// Optional ground texture dashes enabled by defining P20_GROUND_TEXTURE_EN.
module p20_video_out
    import p20_video_pkg::*;
#(
    parameter int unsigned DINO_X      = 64,
    parameter int unsigned GROUND_Y    = 400,
    parameter int unsigned SCROLL_STEP = 4
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic [ADDR_W-1:0]   vaddr,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [DINO_H_W-1:0] dino_h,
    input  logic [ADDR_W-1:0]   obs_x,
    input  logic                game_over,
    input  logic                scroll_en,
    output logic [RGB_W-1:0]    rgb,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_tick,
    output logic                collision
);

    localparam int unsigned DINO_W     = SPRITE_W << SCALE_SHIFT;
    localparam int unsigned DINO_BOX_H = SPRITE_H << SCALE_SHIFT;
    localparam int unsigned SW         = ADDR_W + 1;

    logic                 tick_c;
    logic [DINO_H_W-1:0]  dino_h_s;
    logic [ADDR_W-1:0]    obs_x_s;
    logic                 go_s;
    logic                 coll_acc;
    pix_flags_t           s1;
    pix_flags_t           s1_c;
    logic                 hs1;
    logic                 vs1;
    logic signed [SW-1:0] y_s;
    logic signed [SW-1:0] dino_bot;
    logic signed [SW-1:0] dino_top;
    logic                 dash_c;
    logic [SPRITE_W-1:0]  rom_row_c;
    logic                 dino_bit_c;
    logic                 coll_hit_c;
    logic [RGB_W-1:0]     pix_c;
    logic [RGB_W-1:0]     rgb_c;

    assign tick_c = (vaddr == ADDR_W'(TICK_ROW)) && (haddr == '0);

    // Shadowed game state, frame tick and collision reporting.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_tick <= 1'b0;
            collision  <= 1'b0;
            coll_acc   <= 1'b0;
            dino_h_s   <= '0;
            obs_x_s    <= '1;
            go_s       <= 1'b0;
        end else begin
            frame_tick <= tick_c;
            if (tick_c) begin
                dino_h_s  <= dino_h;
                obs_x_s   <= obs_x;
                go_s      <= game_over;
                collision <= coll_acc;
                coll_acc  <= 1'b0;
            end else if (coll_hit_c) begin
                coll_acc  <= 1'b1;
            end
        end
    end

`ifdef P20_GROUND_TEXTURE_EN
    logic [ADDR_W-1:0] scroll;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            scroll <= '0;
        end else if (tick_c && scroll_en && !game_over) begin
            scroll <= scroll + ADDR_W'(SCROLL_STEP);
        end
    end

    assign dash_c = ((vaddr == ADDR_W'(GROUND_Y + 4)) || (vaddr == ADDR_W'(GROUND_Y + 5)))
                 && ((((haddr + scroll) >> 3) & ADDR_W'(1)) != '0);
`else
    logic unused_ok;

    assign dash_c    = 1'b0;
    assign unused_ok = &{1'b0, scroll_en, ADDR_W'(SCROLL_STEP)};
`endif

    // Dino box bounds in signed arithmetic so a tall jump cannot wrap.
    assign y_s      = SW'(vaddr);
    assign dino_bot = SW'(GROUND_Y) - SW'(dino_h_s);
    assign dino_top = dino_bot - SW'(DINO_BOX_H);

    // Stage 1 classification.
    always_comb begin
        s1_c        = '0;
        s1_c.vis    = (haddr < ADDR_W'(H_VISIBLE)) && (vaddr < ADDR_W'(V_VISIBLE));
        s1_c.dino   = (haddr >= ADDR_W'(DINO_X)) && (haddr < ADDR_W'(DINO_X + DINO_W))
                   && (y_s >= dino_top) && (y_s < dino_bot);
        s1_c.obs    = (obs_x_s < ADDR_W'(H_VISIBLE))
                   && ({1'b0, haddr} >= {1'b0, obs_x_s})
                   && ({1'b0, haddr} < ({1'b0, obs_x_s} + SW'(OBS_W)))
                   && (vaddr >= ADDR_W'(GROUND_Y - OBS_H))
                   && (vaddr < ADDR_W'(GROUND_Y));
        s1_c.ground = (vaddr == ADDR_W'(GROUND_Y)) || (vaddr == ADDR_W'(GROUND_Y + 1)) || dash_c;
        s1_c.row    = ROW_W'(SW'(y_s - dino_top) >> SCALE_SHIFT);
        s1_c.col    = ROW_W'((haddr - ADDR_W'(DINO_X)) >> SCALE_SHIFT);
    end

    p20_dino_rom u_rom (
        .row  (s1.row),
        .data (rom_row_c)
    );

    // Stage 2: sprite bit select and colour priority.
    assign dino_bit_c = rom_row_c[~s1.col];
    assign coll_hit_c = s1.vis && s1.dino && dino_bit_c && s1.obs;

    always_comb begin
        pix_c = COL_BG;
        if (s1.dino && dino_bit_c) begin
            pix_c = COL_DINO;
        end else if (s1.obs) begin
            pix_c = COL_OBS;
        end else if (s1.ground) begin
            pix_c = COL_GROUND;
        end
        rgb_c = s1.vis ? (pix_c ^ {RGB_W{go_s}}) : '0;
    end

    // Pixel and sync pipeline, kept in lockstep.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1    <= '0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            s1    <= s1_c;
            hs1   <= hsync_in;
            vs1   <= vsync_in;
            rgb   <= rgb_c;
            hsync <= hs1;
            vsync <= vs1;
        end
    end

endmodule

// File: tb/tb_p20_video_out.sv
// Directed, table-driven bench for p20_video_out.
module tb_p20_video_out;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [9:0] vaddr;
    logic [9:0] haddr;
    logic       hsync_in;
    logic       vsync_in;
    logic [6:0] dino_h;
    logic [9:0] obs_x;
    logic       game_over;
    logic       scroll_en;
    logic [5:0] rgb;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
    logic       collision;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] dh;
        logic [9:0] ox;
        logic       go;
        logic [9:0] v;
        logic [9:0] h;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    p20_video_out dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .vaddr      (vaddr),
        .haddr      (haddr),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .dino_h     (dino_h),
        .obs_x      (obs_x),
        .game_over  (game_over),
        .scroll_en  (scroll_en),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] dh, input logic [9:0] ox, input logic go,
                       input logic [9:0] v, input logic [9:0] h, input logic [5:0] exp);
        vec_t t;
        t.dh = dh; t.ox = ox; t.go = go; t.v = v; t.h = h; t.exp = exp;
        vecs.push_back(t);
    endtask

    // Present one pixel address and check rgb after the 2-cycle pipeline.
    task automatic pix(input string name, input logic [9:0] v, input logic [9:0] h, input logic [5:0] exp);
        vaddr = v;
        haddr = h;
        repeat (2) @(negedge clk);
        check(name, 32'(rgb), 32'(exp));
    endtask

    // Blank column, then the tick address, as a real scan would approach it.
    task automatic do_tick(input logic exp_coll);
        vaddr = 10'd479;
        haddr = 10'd800;
        repeat (2) @(negedge clk);
        vaddr = 10'd480;
        haddr = 10'd0;
        @(negedge clk);
        check("frame_tick_high", 32'(frame_tick), 32'd1);
        check("collision_at_tick", 32'(collision), 32'(exp_coll));
        haddr = 10'd1;
        @(negedge clk);
        check("frame_tick_low", 32'(frame_tick), 32'd0);
    endtask

    task automatic sync_test(input bit is_v);
        logic o;
        if (is_v) vsync_in = 1'b0; else hsync_in = 1'b0;
        @(negedge clk);
        o = is_v ? vsync : hsync;
        check(is_v ? "vsync_n1" : "hsync_n1", 32'(o), 32'd1);
        @(negedge clk);
        o = is_v ? vsync : hsync;
        check(is_v ? "vsync_n2" : "hsync_n2", 32'(o), 32'd0);
        repeat (94) @(negedge clk);
        if (is_v) vsync_in = 1'b1; else hsync_in = 1'b1;
        @(negedge clk);
        o = is_v ? vsync : hsync;
        check(is_v ? "vsync_n97" : "hsync_n97", 32'(o), 32'd0);
        @(negedge clk);
        o = is_v ? vsync : hsync;
        check(is_v ? "vsync_n98" : "hsync_n98", 32'(o), 32'd1);
    endtask

    initial begin
        bit have_state;
        int tick_cnt;

        vaddr = 10'd0; haddr = 10'd0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        dino_h = 7'd0; obs_x = 10'd700; game_over = 1'b0; scroll_en = 1'b1;

        // Colour table: dino at ground, obstacle at x=200
        add(7'd0, 10'd200, 1'b0, 10'd100, 10'd640, 6'h00);
        add(7'd0, 10'd200, 1'b0, 10'd300, 10'd10,  6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd368, 10'd64,  6'h15);
        add(7'd0, 10'd200, 1'b0, 10'd368, 10'd68,  6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd368, 10'd80,  6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd368, 10'd83,  6'h15);
        add(7'd0, 10'd200, 1'b0, 10'd368, 10'd96,  6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd399, 10'd64,  6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd399, 10'd70,  6'h15);
        add(7'd0, 10'd200, 1'b0, 10'd400, 10'd64,  6'h2A);
        add(7'd0, 10'd200, 1'b0, 10'd370, 10'd200, 6'h08);
        add(7'd0, 10'd200, 1'b0, 10'd370, 10'd215, 6'h08);
        add(7'd0, 10'd200, 1'b0, 10'd370, 10'd216, 6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd367, 10'd200, 6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd399, 10'd205, 6'h08);
        add(7'd0, 10'd200, 1'b0, 10'd400, 10'd205, 6'h2A);
        add(7'd0, 10'd200, 1'b0, 10'd401, 10'd300, 6'h2A);
        add(7'd0, 10'd200, 1'b0, 10'd402, 10'd300, 6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd479, 10'd639, 6'h3F);
        add(7'd0, 10'd200, 1'b0, 10'd480, 10'd10,  6'h00);
        add(7'd0, 10'd200, 1'b0, 10'd100, 10'd800, 6'h00);
        add(7'd0, 10'd200, 1'b0, 10'd0,   10'd0,   6'h3F);
        // Game over palette
        add(7'd0, 10'd200, 1'b1, 10'd368, 10'd64,  6'h2A);
        add(7'd0, 10'd200, 1'b1, 10'd300, 10'd10,  6'h00);
        add(7'd0, 10'd200, 1'b1, 10'd100, 10'd640, 6'h00);
        add(7'd0, 10'd200, 1'b1, 10'd370, 10'd200, 6'h37);
        add(7'd0, 10'd200, 1'b1, 10'd400, 10'd205, 6'h15);
        // Jumping dino, no obstacle
        add(7'd100, 10'd700, 1'b0, 10'd268, 10'd64, 6'h15);
        add(7'd100, 10'd700, 1'b0, 10'd267, 10'd64, 6'h3F);
        add(7'd100, 10'd700, 1'b0, 10'd299, 10'd70, 6'h15);
        add(7'd100, 10'd700, 1'b0, 10'd300, 10'd70, 6'h3F);
        add(7'd100, 10'd700, 1'b0, 10'd368, 10'd64, 6'h3F);
        add(7'd100, 10'd700, 1'b0, 10'd370, 10'd200, 6'h3F);

        // Reset state
        #1 sys_rst = 1'b1;
        #2;
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_hsync", 32'(hsync), 32'd1);
        hsync_in = 1'b1; vsync_in = 1'b1;
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven pixel checks, latching game state when it changes
        have_state = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (!have_state || vecs[i].dh != dino_h || vecs[i].ox != obs_x || vecs[i].go != game_over) begin
                dino_h = vecs[i].dh;
                obs_x = vecs[i].ox;
                game_over = vecs[i].go;
                do_tick(1'b0);
                have_state = 1'b1;
            end
            pix($sformatf("pix%0d", i), vecs[i].v, vecs[i].h, vecs[i].exp);
        end
        game_over = 1'b0;

        // Sync alignment
        vaddr = 10'd10; haddr = 10'd700;
        sync_test(1'b0);
        sync_test(1'b1);

        // Exactly one tick pulse across the frame boundary
        tick_cnt = 0;
        vaddr = 10'd479;
        for (int h = 780; h <= 800; h++) begin
            haddr = 10'(h);
            @(negedge clk);
            tick_cnt += int'(frame_tick);
        end
        vaddr = 10'd480;
        for (int h = 0; h < 16; h++) begin
            haddr = 10'(h);
            @(negedge clk);
            tick_cnt += int'(frame_tick);
        end
        check("tick_count", 32'(tick_cnt), 32'd1);

        // Obstacle position is shadowed until the next tick
        dino_h = 7'd0; obs_x = 10'd700;
        do_tick(1'b0);
        vaddr = 10'd100;
        obs_x = 10'd200;
        pix("shadow_mid", 10'd100, 10'd300, 6'h3F);
        pix("shadow_pre", 10'd370, 10'd200, 6'h3F);
        do_tick(1'b0);
        pix("shadow_post", 10'd370, 10'd200, 6'h08);

        // Collision reported for the frame after an overlap
        obs_x = 10'd64;
        do_tick(1'b0);
        pix("coll_pix1", 10'd368, 10'd64, 6'h15);
        obs_x = 10'd600;
        do_tick(1'b1);
        pix("coll_pix2", 10'd368, 10'd64, 6'h15);
        check("coll_held", 32'(collision), 32'd1);
        do_tick(1'b0);
        obs_x = 10'd64;
        do_tick(1'b0);
        pix("coll_pix3", 10'd368, 10'd64, 6'h15);
        obs_x = 10'd200;
        do_tick(1'b1);

        // Mid-line reset with rgb non-zero and hsync low
        hsync_in = 1'b0;
        pix("pre_rst_rgb", 10'd300, 10'd10, 6'h3F);
        check("pre_rst_hsync", 32'(hsync), 32'd0);
        @(posedge clk);
        #2 sys_rst = 1'b1;
        #1;
        check("mid_rst_rgb", 32'(rgb), 32'd0);
        check("mid_rst_hsync", 32'(hsync), 32'd1);
        check("mid_rst_vsync", 32'(vsync), 32'd1);
        check("mid_rst_collision", 32'(collision), 32'd0);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        check("post_rst_rgb_n1", 32'(rgb), 32'd0);
        check("post_rst_hsync_n1", 32'(hsync), 32'd1);
        @(negedge clk);
        check("post_rst_rgb_n2", 32'(rgb), 32'h3F);
        check("post_rst_hsync_n2", 32'(hsync), 32'd0);
        hsync_in = 1'b1;
        pix("post_rst_obs_shadow", 10'd370, 10'd200, 6'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p20_video_out.md
# p20_video_out

Pixel renderer for the dino game, directly downstream of the VGA timing generator (`p20_vga`). It consumes `vaddr`/`haddr`/`hsync`/`vsync` and per-frame game state, and produces 6-bit RGB plus sync outputs. RGB and sync outputs are delayed by the same 2-cycle pipeline so they stay aligned. It also generates the frame tick that paces game logic, latches game state once per frame to avoid tearing, and reports sprite/obstacle pixel collision.

## Interface
- `DINO_X`, 64: dino sprite left edge, screen x.
- `GROUND_Y`, 400: ground line row; sprite/obstacle bottoms sit on `GROUND_Y-1`.
- `SCROLL_STEP`, 4: ground scroll advance per frame.
- `clk`  in  1  pixel clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `vaddr`  in  10  current row from timing generator.
- `haddr`  in  10  current column from timing generator.
- `hsync_in`  in  1  horizontal sync from timing generator, active low.
- `vsync_in`  in  1  vertical sync from timing generator, active low.
- `dino_h`  in  7  dino height above ground, 0..127.
- `obs_x`  in  10  obstacle left edge; ≥640 means no obstacle drawn.
- `game_over`  in  1  freeze scroll, invert palette.
- `scroll_en`  in  1  allow ground scroll advance.
- `rgb`  out  6  {r[1:0],g[1:0],b[1:0]}.
- `hsync`  out  1  `hsync_in` delayed 2 cycles.
- `vsync`  out  1  `vsync_in` delayed 2 cycles.
- `frame_tick`  out  1  one-cycle pulse per frame.
- `collision`  out  1  previous frame had a dino/obstacle overlap; held for one frame.

## Operation
- Tick detect (combinational): `vaddr==480 && haddr==0`. The following all happen on the same edge:
  - `frame_tick` register goes to 1.
  - Shadow registers `dino_h_s` and `obs_x_s` load from their inputs.
  - `go_s` loads from `game_over`.
  - `scroll` advances by `SCROLL_STEP`, mod 1024, if `scroll_en && !game_over`.
  - `collision` loads from `coll_acc`, and `coll_acc` clears.
- Visible region: `haddr<640 && vaddr<480`. Outside it, `rgb` is 0 regardless of the `go_s` palette.
- Dino box:
  - x in [DINO_X, DINO_X+32), y in [GROUND_Y-32-dino_h_s, GROUND_Y-dino_h_s). Compute with 11-bit signed arithmetic; rows <0 are never drawn.
  - Sprite is 16x16 at 1bpp, drawn at 2x scale: row = (y-top)>>1, col = (x-DINO_X)>>1. ROM bit 15 is the leftmost column.
- Obstacle box: x in [obs_x_s, obs_x_s+16), y in [GROUND_Y-32, GROUND_Y). Columns past 639 are clipped.
- Ground: rows GROUND_Y and GROUND_Y+1.
- Priority: opaque dino pixel 6'b010101 > obstacle 6'b001000 > ground 6'b101010 > background 6'b111111.
- When `go_s`=1, every visible colour is XORed with 6'b111111.
- `coll_acc` is set by any visible pixel that is both an opaque dino pixel and in the obstacle box.
  - The tick cycle is never visible, so set and clear cannot coincide. If they did, clear wins.

## Timing
- Stage 1 registers:
  - visible flag.
  - in-dino, in-obstacle and ground flags.
  - sprite row (4b), sprite col (4b).
  - `hsync_in`/`vsync_in`.
- Stage 2:
  - ROM read (combinational from stage-1 row) and bit select.
  - Priority mux, then register into `rgb`/`hsync`/`vsync`.
- Latency is exactly 2 cycles from `haddr`/`vaddr`/`hsync_in`/`vsync_in` to `rgb`/`hsync`/`vsync`.
- `frame_tick` and `collision` have latency 1 from the tick-detect input sample.
- Reset values (asynchronous):
  - Outputs: `rgb`=0, `hsync`=1, `vsync`=1, `frame_tick`=0, `collision`=0.
  - Internal: `coll_acc`=0, `scroll`=0, `dino_h_s`=0, `obs_x_s`=10'h3FF, `go_s`=0.
  - All pipeline flags reset to 0 and both sync pipeline stages to 1.
- Reset asserted mid-frame: outputs take their reset values immediately. After release, the first valid pixel appears 2 cycles later. Shadows stay at reset values until the next tick.
- The `haddr` value 800 (extra column) is treated as blanking.

## Configuration
- `P20_GROUND_TEXTURE_EN` defined:
  - `scroll` register exists.
  - Rows GROUND_Y+4 and GROUND_Y+5 draw ground-colour dashes where `((haddr+scroll)>>3)&1 == 1`.
- Undefined:
  - No scroll register.
  - Those rows show background; `scroll_en` is ignored.

## Structure
- Shared package `p20_video_pkg`:
  - `H_VISIBLE`=640, `V_VISIBLE`=480, `TICK_ROW`=480.
  - `SPRITE_W`=16, `SPRITE_H`=16, `SCALE_SHIFT`=1.
  - `OBS_W`=16, `OBS_H`=32.
  - The four colour constants.
- Sub-module `p20_dino_rom`: 16-entry x 16-bit combinational sprite ROM, 4-bit row in, 16-bit row out.

## Test plan
- Reset mid-line, with `rgb` non-zero: assert `sys_rst` between edges → `rgb`=0, `hsync`=`vsync`=1 before the next edge; `collision`=0.
- Drive `hsync_in` low at cycle N → `hsync` low at N+2 and high again 96 cycles later; `vsync` likewise.
- Blanking: `haddr`=640, `vaddr`=100 → `rgb`=0 two cycles later. `vaddr`=300, `haddr`=10 → 6'b111111.
- Dino draw: `dino_h`=0 latched at a tick, ROM row0 bit15=1, pixel (64,368) → `rgb`=6'b010101. With `game_over` latched → 6'b101010.
- Shadowing:
  - Change `obs_x` 700→200 at `vaddr`=100 → no obstacle drawn until after the tick.
  - `frame_tick` high for exactly one cycle per 801x526-cycle frame.
- Collision: latch `obs_x`=64, `dino_h`=0 → `collision`=1 after the following tick. Latch `obs_x`=600 → `collision`=0 one frame later.
